// File: rtl/add_sub_accum_if.sv
// Result bus between the adder/subtractor stage, the frame accumulator and its consumer.
// The master side drives the samples and controls, and the slave side is the accumulator.
interface add_sub_accum_if #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 12,
  parameter int LEN_W = 4
);
  logic             start;
  logic [LEN_W-1:0] frame_len;
  logic             in_valid;
  logic [WIDTH:0]   add_in;
  logic [WIDTH:0]   sub_in;
  logic [ACC_W-1:0] acc_add;
  logic [ACC_W-1:0] acc_sub;
  logic             ovf_add;
  logic             ovf_sub;
  logic             dropped;
  logic             busy;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output start, frame_len, in_valid, add_in, sub_in, out_ready,
    input  acc_add, acc_sub, ovf_add, ovf_sub, dropped, busy, out_valid
  );

  modport slave (
    input  start, frame_len, in_valid, add_in, sub_in, out_ready,
    output acc_add, acc_sub, ovf_add, ovf_sub, dropped, busy, out_valid
  );
endinterface

// File: rtl/add_sub_accum.sv
// Frame accumulator for unsigned sums and signed differences, with saturating totals.
// Each finished frame is held on a valid/ready output until the consumer takes it.
module add_sub_accum #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 12,
  parameter int LEN_W = 4
) (
  input  logic clk,
  input  logic rst,
  add_sub_accum_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  state_t           state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic [ACC_W-1:0] acc_add_q;
  logic [ACC_W-1:0] acc_sub_q;
  logic             ovf_add_q;
  logic             ovf_sub_q;
  logic             dropped_q;
  logic             busy_q;
  logic             out_valid_q;

  logic [ACC_W:0]   add_sum;
  logic [ACC_W:0]   sub_sum;
  logic             add_clip;
  logic             sub_clip;
  logic [ACC_W-1:0] acc_add_d;
  logic [ACC_W-1:0] acc_sub_d;

  // One guard bit is enough because a single sample is narrower than the accumulator.
  always_comb begin
    add_sum  = {1'b0, acc_add_q} + {{(ACC_W-WIDTH){1'b0}}, bus.add_in};
    sub_sum  = {acc_sub_q[ACC_W-1], acc_sub_q} + {{(ACC_W-WIDTH){bus.sub_in[WIDTH]}}, bus.sub_in};
    add_clip = add_sum[ACC_W];
    sub_clip = sub_sum[ACC_W] ^ sub_sum[ACC_W-1];
    acc_add_d = add_clip ? {ACC_W{1'b1}} : add_sum[ACC_W-1:0];
    if (!sub_clip) begin
      acc_sub_d = sub_sum[ACC_W-1:0];
    end else if (sub_sum[ACC_W]) begin
      acc_sub_d = {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      acc_sub_d = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      acc_add_q   <= '0;
      acc_sub_q   <= '0;
      ovf_add_q   <= 1'b0;
      ovf_sub_q   <= 1'b0;
      dropped_q   <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q   <= S_ACCUM;
            len_q     <= bus.frame_len;
            cnt_q     <= '0;
            acc_add_q <= '0;
            acc_sub_q <= '0;
            ovf_add_q <= 1'b0;
            ovf_sub_q <= 1'b0;
            // A sample coinciding with the start edge is not part of the frame.
            dropped_q <= bus.in_valid;
            busy_q    <= 1'b1;
          end else if (bus.in_valid) begin
            dropped_q <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (bus.in_valid) begin
            acc_add_q <= acc_add_d;
            acc_sub_q <= acc_sub_d;
            ovf_add_q <= ovf_add_q | add_clip;
            ovf_sub_q <= ovf_sub_q | sub_clip;
            cnt_q     <= cnt_q + 1'b1;
            if (cnt_q == len_q) begin
              state_q     <= S_HOLD;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (bus.in_valid) begin
            dropped_q <= 1'b1;
          end
          if (bus.out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.acc_add   = acc_add_q;
  assign bus.acc_sub   = acc_sub_q;
  assign bus.ovf_add   = ovf_add_q;
  assign bus.ovf_sub   = ovf_sub_q;
  assign bus.dropped   = dropped_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;

endmodule
